// File: rtl/caq_tape_pkg.sv
// Shared types and constants for the CAQ cassette playback engine.
package caq_tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        GAP
    } tape_state_t;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_HALF0     = 2;
    localparam int DEF_HALF1     = 1;
    localparam int DEF_STOP_BITS = 2;
    localparam int DEF_GAP_TICKS = 64;

    // Width of the per-symbol tick position counter inside the bit generator.
    localparam int SYM_CNT_W = 8;

    // Symbols per frame: one start bit, eight data bits, then the stop bits.
    function automatic int frame_len(input int stop_bits);
        return 9 + stop_bits;
    endfunction

endpackage

// File: rtl/tape_bit_gen.sv
// FSK symbol generator: each symbol is a high half followed by a low half,
// both HALF0 (symbol '0') or HALF1 (symbol '1') ce ticks long. A symbol
// requested with start is queued and begins on the tick that completes the
// current symbol (or on the next tick when idle), so symbols chain seamlessly.
// symbol_done fires on the tick that enters the final tick of a symbol, giving
// the caller one tick of slack to queue the next symbol or fetch the next byte;
// symbol_end fires on the tick that completes the symbol.
module tape_bit_gen
    import caq_tape_pkg::*;
#(
    parameter int HALF0 = DEF_HALF0,
    parameter int HALF1 = DEF_HALF1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic hold,
    input  logic clear,
    input  logic start,
    input  logic symbol,
    output logic level,
    output logic symbol_done,
    output logic symbol_end
);

    localparam int CW = SYM_CNT_W;
    localparam logic [CW-1:0] H0    = CW'(HALF0);
    localparam logic [CW-1:0] H1    = CW'(HALF1);
    localparam logic [CW-1:0] LAST0 = CW'(2 * HALF0 - 1);
    localparam logic [CW-1:0] LAST1 = CW'(2 * HALF1 - 1);

    logic          busy;
    logic          armed;
    logic          pend;
    logic          sym;
    logic [CW-1:0] pos;
    logic [CW-1:0] pos_inc;
    logic [CW-1:0] half_len;
    logic [CW-1:0] last_pos;
    logic          tick;
    logic          armed_now;
    logic          pend_now;

    assign tick      = ce & ~hold;
    assign pos_inc   = pos + CW'(1);
    assign half_len  = sym ? H1 : H0;
    assign last_pos  = sym ? LAST1 : LAST0;
    assign armed_now = armed | start;
    assign pend_now  = start ? symbol : pend;

    assign symbol_done = tick & busy & (pos_inc == last_pos);
    assign symbol_end  = tick & busy & (pos == last_pos);

    // Advance the half-period position on each unheld tick and start queued symbols.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            armed <= 1'b0;
            pend  <= 1'b0;
            sym   <= 1'b0;
            pos   <= '0;
            level <= 1'b0;
        end else if (clear) begin
            busy  <= 1'b0;
            armed <= 1'b0;
            pos   <= '0;
            level <= 1'b0;
        end else begin
            if (start) begin
                armed <= 1'b1;
                pend  <= symbol;
            end
            if (tick) begin
                if (busy && pos != last_pos) begin
                    pos   <= pos_inc;
                    level <= (pos_inc < half_len);
                end else if (armed_now) begin
                    busy  <= 1'b1;
                    armed <= 1'b0;
                    sym   <= pend_now;
                    pos   <= '0;
                    level <= 1'b1;
                end else begin
                    busy  <= 1'b0;
                    pos   <= '0;
                    level <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/caq_tape_player.sv
// CAQ tape playback engine: fetches image bytes from tape RAM and serialises
// them as framed FSK symbols, with play/stop/pause, loop and reload control.
// GAP_TICKS must be at least 2.
module caq_tape_player
    import caq_tape_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int HALF0     = DEF_HALF0,
    parameter int HALF1     = DEF_HALF1,
    parameter int STOP_BITS = DEF_STOP_BITS,
    parameter int GAP_TICKS = DEF_GAP_TICKS,
    parameter int AUTOPLAY  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_tape,
    input  logic              load,
    input  logic [ADDR_W-1:0] length,
    input  logic              play,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              out,
    output logic              req,
    output logic              done,
    output logic [ADDR_W-1:0] pos
);

    localparam int              FRAME    = frame_len(STOP_BITS);
    localparam logic [3:0]      LAST_BIT = 4'(FRAME - 1);
    localparam int              GW       = $clog2(GAP_TICKS + 1);
    localparam logic [GW-1:0]   GAP_END  = GW'(GAP_TICKS - 2);

    tape_state_t       state;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] addr_inc;
    logic [FRAME-1:0]  frame;
    logic [3:0]        bit_cnt;
    logic              tail;
    logic [GW-1:0]     gap_cnt;
    logic              gap_tick;
    logic              load_take;
    logic              gen_start;
    logic              gen_symbol;
    logic              gen_clear;
    logic              sym_done;
    logic              sym_end;

    assign addr_inc  = mem_addr + ADDR_W'(1);
    assign gap_tick  = ce_tape & ~pause;
    assign load_take = load & ((length != '0) | (state != IDLE));
    assign gen_clear = stop | load_take;

    // Queue the start bit when a byte is latched, otherwise the next frame bit
    // when the current symbol enters its final tick.
    always_comb begin
        gen_start  = 1'b0;
        gen_symbol = 1'b0;
        if (state == LATCH) begin
            gen_start = 1'b1;
        end else if (state == SEND && sym_done && bit_cnt != LAST_BIT) begin
            gen_start  = 1'b1;
            gen_symbol = frame[1];
        end
    end

    tape_bit_gen #(
        .HALF0 (HALF0),
        .HALF1 (HALF1)
    ) u_bit_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce_tape),
        .hold        (pause),
        .clear       (gen_clear),
        .start       (gen_start),
        .symbol      (gen_symbol),
        .level       (out),
        .symbol_done (sym_done),
        .symbol_end  (sym_end)
    );

    // Playback FSM: control pulses first, then byte fetch, framing, gap and end handling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            len_q    <= '0;
            mem_addr <= '0;
            pos      <= '0;
            frame    <= '0;
            bit_cnt  <= '0;
            tail     <= 1'b0;
            gap_cnt  <= '0;
            req      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_take) begin
                len_q <= length;
            end
            if (stop) begin
                state    <= IDLE;
                mem_addr <= '0;
                tail     <= 1'b0;
                req      <= 1'b0;
            end else if (load_take) begin
                mem_addr <= '0;
                tail     <= 1'b0;
                if (AUTOPLAY != 0 && length != '0) begin
                    state <= FETCH;
                    req   <= 1'b1;
                end else begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (play && len_q != '0) begin
                            state <= FETCH;
                            req   <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        frame   <= {{STOP_BITS{1'b1}}, mem_data, 1'b0};
                        pos     <= mem_addr;
                        bit_cnt <= '0;
                        tail    <= 1'b0;
                        state   <= SEND;
                    end
                    SEND: begin
                        if (sym_done) begin
                            if (bit_cnt != LAST_BIT) begin
                                bit_cnt <= bit_cnt + 4'd1;
                                frame   <= frame >> 1;
                            end else if (addr_inc < len_q) begin
                                mem_addr <= addr_inc;
                                state    <= FETCH;
                            end else begin
                                tail <= 1'b1;
                            end
                        end else if (sym_end && tail) begin
                            tail <= 1'b0;
                            if (loop_en) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                done     <= 1'b1;
                                mem_addr <= '0;
                                req      <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_tick) begin
                            if (gap_cnt == GAP_END) begin
                                mem_addr <= '0;
                                if (loop_en) begin
                                    state <= FETCH;
                                end else begin
                                    done  <= 1'b1;
                                    req   <= 1'b0;
                                    state <= IDLE;
                                end
                            end else begin
                                gap_cnt <= gap_cnt + GW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        req   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
